// File: rtl/display_select_sequencer.sv
// Debug display select sequencer: manual/step/auto-scan select generation with
// a debounced step key and a sticky memory-error hold on ERR_SELECT.
module display_select_sequencer #(
  parameter int unsigned NUM_SELECTS     = 25,
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned ERR_SELECT      = 24
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [1:0] Mode,
  input  logic [4:0] Switch_Select,
  input  logic       Step_Button,
  input  logic       Blank_Request,
  input  logic       MEM_ERROR,
  input  logic       Error_Clear,
  output logic [4:0] Display_Select,
  output logic       Display_Enable,
  output logic       Select_Changed,
  output logic       Error_Latched
);

  localparam int unsigned SEL_W   = 5;
  localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_MANUAL   = 2'd0,
    ST_STEP     = 2'd1,
    ST_SCAN     = 2'd2,
    ST_ERR_HOLD = 2'd3
  } state_e;

  state_e             state_q, state_d, mode_state_c;
  logic               sync1_q, sync2_q;
  logic               key_acc_q, key_acc_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   sel_q, sel_d, next_sel_c;
  logic               en_q, en_d;
  logic               chg_q, chg_d;
  logic               err_q, err_d;
  logic               press_c;

  // Key path: two-flop synchronizer and debounce; idle level is released (1)
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      key_acc_q <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= Step_Button;
      sync2_q   <= sync1_q;
      key_acc_q <= key_acc_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_comb begin
    deb_cnt_d = '0;
    key_acc_d = key_acc_q;
    if (sync2_q != key_acc_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_acc_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign press_c = key_acc_q & ~key_acc_d;

  always_comb begin
    case (Mode)
      2'b01:   mode_state_c = ST_STEP;
      2'b10:   mode_state_c = ST_SCAN;
      default: mode_state_c = ST_MANUAL;
    endcase
  end

  assign next_sel_c = (sel_q == SEL_W'(NUM_SELECTS - 1)) ? '0 : sel_q + SEL_W'(1);

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: error entry wins over everything; hold releases only on clean clear
  always_comb begin
    state_d = state_q;
    if (state_q == ST_ERR_HOLD) begin
      if (Error_Clear && !MEM_ERROR) begin
        state_d = mode_state_c;
      end
    end else if (MEM_ERROR) begin
      state_d = ST_ERR_HOLD;
    end else begin
      state_d = mode_state_c;
    end
  end

  // Outputs and datapath; a mode change only clears dwell and keeps the select
  always_comb begin
    sel_d   = sel_q;
    dwell_d = '0;
    if (state_q != ST_ERR_HOLD && MEM_ERROR) begin
      sel_d = SEL_W'(ERR_SELECT);
    end else if (state_q != ST_ERR_HOLD && mode_state_c == state_q) begin
      case (state_q)
        ST_MANUAL: sel_d = (32'(Switch_Select) < NUM_SELECTS) ? Switch_Select : '0;
        ST_STEP:   if (press_c) sel_d = next_sel_c;
        ST_SCAN: begin
          if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
            sel_d = next_sel_c;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        default: sel_d = sel_q;
      endcase
    end
    en_d  = (state_d == ST_ERR_HOLD) ? 1'b0 : Blank_Request;
    err_d = (state_d == ST_ERR_HOLD);
    chg_d = (sel_d != sel_q);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sel_q   <= '0;
      dwell_q <= '0;
      en_q    <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      en_q    <= en_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  assign Display_Select = sel_q;
  assign Display_Enable = en_q;
  assign Select_Changed = chg_q;
  assign Error_Latched  = err_q;

endmodule

// File: tb/tb_display_select_sequencer.sv
// Bench for display_select_sequencer: manual vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_display_select_sequencer;

  localparam int NSEL  = 25;
  localparam int DWELL = 4;
  localparam int DEB   = 3;
  localparam int ERRS  = 24;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [1:0] Mode;
  logic [4:0] Switch_Select;
  logic       Step_Button;
  logic       Blank_Request;
  logic       MEM_ERROR;
  logic       Error_Clear;
  logic [4:0] Display_Select;
  logic       Display_Enable;
  logic       Select_Changed;
  logic       Error_Latched;

  display_select_sequencer #(
    .NUM_SELECTS(NSEL), .DWELL_CYCLES(DWELL), .DEBOUNCE_CYCLES(DEB), .ERR_SELECT(ERRS)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Mode(Mode), .Switch_Select(Switch_Select),
    .Step_Button(Step_Button), .Blank_Request(Blank_Request), .MEM_ERROR(MEM_ERROR),
    .Error_Clear(Error_Clear), .Display_Select(Display_Select),
    .Display_Enable(Display_Enable), .Select_Changed(Select_Changed),
    .Error_Latched(Error_Latched)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model state (operating mode 0 manual, 1 step, 2 scan)
  int m_mode, m_sel, m_elapsed, m_run;
  bit m_err, m_en, m_chg;
  bit key_hist [2];
  bit m_acc;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_elapsed = 0; m_run = 0;
    m_err = 0; m_en = 0; m_chg = 0;
    key_hist[0] = 1; key_hist[1] = 1; m_acc = 1;
  endtask

  // One clock of the specification's rules, using the currently driven inputs
  task automatic model_tick();
    int  want_mode;
    int  old_sel;
    bit  press;
    bit  synced;
    press  = 0;
    synced = key_hist[1];
    if (synced != m_acc) begin
      m_run++;
      if (m_run == DEB) begin
        press = (m_acc == 1) && (synced == 0);
        m_acc = synced;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    key_hist[1] = key_hist[0];
    key_hist[0] = Step_Button;

    want_mode = (Mode == 2'b01) ? 1 : (Mode == 2'b10) ? 2 : 0;
    old_sel = m_sel;
    if (m_err) begin
      if (Error_Clear && !MEM_ERROR) begin
        m_err = 0; m_mode = want_mode; m_elapsed = 0;
      end
    end else if (MEM_ERROR) begin
      m_err = 1; m_sel = ERRS; m_elapsed = 0;
    end else if (want_mode != m_mode) begin
      m_mode = want_mode; m_elapsed = 0;
    end else if (m_mode == 0) begin
      m_sel = (int'(Switch_Select) < NSEL) ? int'(Switch_Select) : 0;
    end else if (m_mode == 1) begin
      if (press) m_sel = (m_sel + 1) % NSEL;
    end else begin
      m_elapsed++;
      if (m_elapsed == DWELL) begin
        m_elapsed = 0;
        m_sel = (m_sel + 1) % NSEL;
      end
    end
    m_en  = m_err ? 1'b0 : Blank_Request;
    m_chg = (m_sel != old_sel);
  endtask

  task automatic cycle();
    model_tick();
    @(posedge Clock);
    #1;
    check("sel", int'(Display_Select), m_sel);
    check("enable", int'(Display_Enable), int'(m_en));
    check("changed", int'(Select_Changed), int'(m_chg));
    check("latched", int'(Error_Latched), int'(m_err));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge
  task automatic mid_reset();
    #2 Resetn = 1'b0;
    model_reset();
    #1;
    check("rst_sel", int'(Display_Select), 0);
    check("rst_enable", int'(Display_Enable), 0);
    check("rst_changed", int'(Select_Changed), 0);
    check("rst_latched", int'(Error_Latched), 0);
    @(posedge Clock);
    #1 Resetn = 1'b1;
  endtask

  typedef struct {
    logic [4:0] sw;
    logic       blank;
    int         exp_sel;
    int         exp_en;
    int         exp_chg;
  } man_vec_t;

  man_vec_t vecs [8];

  initial begin
    vecs[0] = '{5'd7,  1'b0, 7,  0, 1};
    vecs[1] = '{5'd30, 1'b0, 0,  0, 1};
    vecs[2] = '{5'd24, 1'b0, 24, 0, 1};
    vecs[3] = '{5'd25, 1'b0, 0,  0, 1};
    vecs[4] = '{5'd0,  1'b1, 0,  1, 0};
    vecs[5] = '{5'd31, 1'b0, 0,  0, 0};
    vecs[6] = '{5'd12, 1'b0, 12, 0, 1};
    vecs[7] = '{5'd12, 1'b0, 12, 0, 0};

    Resetn = 1'b0; Mode = 2'b00; Switch_Select = '0; Step_Button = 1'b1;
    Blank_Request = 1'b0; MEM_ERROR = 1'b0; Error_Clear = 1'b0;
    model_reset();
    @(posedge Clock); @(posedge Clock); #1;
    check("reset_sel", int'(Display_Select), 0);
    check("reset_enable", int'(Display_Enable), 0);
    check("reset_changed", int'(Select_Changed), 0);
    check("reset_latched", int'(Error_Latched), 0);
    Resetn = 1'b1;

    // Manual mode vectors
    for (int i = 0; i < 8; i++) begin
      Switch_Select = vecs[i].sw;
      Blank_Request = vecs[i].blank;
      cycle();
      check("man_sel", int'(Display_Select), vecs[i].exp_sel);
      check("man_en", int'(Display_Enable), vecs[i].exp_en);
      check("man_chg", int'(Select_Changed), vecs[i].exp_chg);
    end

    // Step: one bouncy press gives exactly one increment
    Switch_Select = 5'd3; cycle();
    Mode = 2'b01; cycle();
    Step_Button = 1'b0; cycle();
    Step_Button = 1'b1; cycle();
    Step_Button = 1'b0; cycles(7);
    Step_Button = 1'b1; cycles(10);
    check("step_3_to_4", int'(Display_Select), 4);

    // Step wrap from the top code
    Mode = 2'b00; Switch_Select = 5'd24; cycles(2);
    Mode = 2'b01; cycle();
    Step_Button = 1'b0; cycles(6);
    Step_Button = 1'b1; cycles(6);
    check("step_wrap", int'(Display_Select), 0);

    // Scan 22 -> 23 -> 24 -> 0, then freeze on switching to step
    Mode = 2'b00; Switch_Select = 5'd22; cycles(2);
    Mode = 2'b10; cycle();
    cycles(3); check("scan_hold_22", int'(Display_Select), 22);
    cycle();   check("scan_23", int'(Display_Select), 23);
    cycles(4); check("scan_24", int'(Display_Select), 24);
    cycles(4); check("scan_wrap_0", int'(Display_Select), 0);
    cycles(2);
    Mode = 2'b01; cycles(8);
    check("scan_frozen", int'(Display_Select), 0);

    // Memory error hold and release
    Mode = 2'b00; Switch_Select = 5'd5; cycles(2);
    Mode = 2'b10; cycles(2);
    MEM_ERROR = 1'b1; cycle();
    check("err_sel", int'(Display_Select), ERRS);
    check("err_latched", int'(Error_Latched), 1);
    MEM_ERROR = 1'b0; cycles(6);
    check("err_held", int'(Error_Latched), 1);
    Error_Clear = 1'b1; MEM_ERROR = 1'b1; cycle();
    check("err_clear_blocked", int'(Error_Latched), 1);
    MEM_ERROR = 1'b0; cycle();
    check("err_released", int'(Error_Latched), 0);
    check("err_sel_kept", int'(Display_Select), ERRS);
    Error_Clear = 1'b0; cycles(3);
    check("resume_hold", int'(Display_Select), ERRS);
    cycle();
    check("resume_wrap", int'(Display_Select), 0);

    // Blanking and its override by an error
    Mode = 2'b00; Switch_Select = 5'd0; Blank_Request = 1'b1; cycles(2);
    check("blank_on", int'(Display_Enable), 1);
    MEM_ERROR = 1'b1; cycle();
    check("blank_forced_off", int'(Display_Enable), 0);
    MEM_ERROR = 1'b0; Error_Clear = 1'b1; cycle();
    Error_Clear = 1'b0; Blank_Request = 1'b0; cycle();

    // Reset mid-scan at 9 with a key press half debounced
    Switch_Select = 5'd9; cycle();
    Mode = 2'b10; cycle();
    Step_Button = 1'b0; cycles(2);
    Blank_Request = 1'b1; cycle();
    check("pre_reset_sel", int'(Display_Select), 9);
    Step_Button = 1'b1; Blank_Request = 1'b0;
    mid_reset();
    Mode = 2'b01; cycles(8);
    check("no_press_after_reset", int'(Display_Select), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) Mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) Switch_Select = 5'($urandom);
      if ($urandom_range(0, 5) == 0) Step_Button = ~Step_Button;
      Blank_Request = ($urandom_range(0, 3) == 0);
      MEM_ERROR     = ($urandom_range(0, 39) == 0);
      Error_Clear   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) mid_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
